tpu_tile_scheduler: RTL

//  Sequences the 4x4 systolic PE array over a full (m x k) * (k x n) matmul of 8-bit operands.

---
 rtl/tpu_tile_scheduler_if.sv | 35 +++
 rtl/tpu_tile_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_scheduler_if.sv
// Tile scheduler bus: job start/done plus the tile command handshake.
// master = scheduler side, slave = host/engine side.
interface tpu_tile_scheduler_if #(
   parameter int DIM_W = 4,
   parameter int IDX_W = 8
);
   logic             start;
   logic [DIM_W-1:0] m;
   logic [DIM_W-1:0] k;
   logic [DIM_W-1:0] n;
   logic             tile_valid;
   logic             tile_ready;
   logic [IDX_W-1:0] a_base;
   logic [IDX_W-1:0] b_base;
   logic [IDX_W-1:0] out_base;
   logic [2:0]       tile_rows;
   logic [2:0]       tile_cols;
   logic [DIM_W-1:0] k_len;
   logic             tile_done;
   logic             busy;
   logic             done;
   logic [4:0]       tile_cnt;

   modport master (
      input  start, m, k, n, tile_ready, tile_done,
      output tile_valid, a_base, b_base, out_base,
      output tile_rows, tile_cols, k_len, busy, done, tile_cnt
   );

   modport slave (
      output start, m, k, n, tile_ready, tile_done,
      input  tile_valid, a_base, b_base, out_base,
      input  tile_rows, tile_cols, k_len, busy, done, tile_cnt
   );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Walks the output of an (m x k)*(k x n) matmul in DIMxDIM tiles,
// row-major, issuing one command per tile and awaiting its completion.
module tpu_tile_scheduler #(
   parameter int DIM   = 4,
   parameter int DIM_W = 4,
   parameter int IDX_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   tpu_tile_scheduler_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] L_DIM = IDX_W'(DIM);
   localparam logic [IDX_W-1:0] L_DM1 = IDX_W'(DIM - 1);
   localparam logic [DIM_W-1:0] L_ONE = DIM_W'(1);

   function automatic logic [IDX_W-1:0] f_wide(
      input logic [DIM_W-1:0] v
   );
      return {{(IDX_W-DIM_W){1'b0}}, v};
   endfunction

   // Number of tiles along one dimension: ceil(dim/DIM).
   function automatic logic [DIM_W-1:0] f_cnt(
      input logic [DIM_W-1:0] dim
   );
      logic [IDX_W-1:0] t;
      t = (f_wide(dim) + L_DM1) / L_DIM;
      return t[DIM_W-1:0];
   endfunction

   // Valid extent of tile t along a dimension: min(DIM, dim - DIM*t).
   function automatic logic [2:0] f_ext(
      input logic [DIM_W-1:0] dim,
      input logic [DIM_W-1:0] t
   );
      logic [IDX_W-1:0] rem;
      rem = f_wide(dim) - f_wide(t) * L_DIM;
      if (rem >= L_DIM) return 3'(DIM);
      return rem[2:0];
   endfunction

   state_t           r_state;
   logic [DIM_W-1:0] r_m;
   logic [DIM_W-1:0] r_k;
   logic [DIM_W-1:0] r_n;
   logic [DIM_W-1:0] r_row;
   logic [DIM_W-1:0] r_col;
   logic             r_valid;
   logic [IDX_W-1:0] r_a_base;
   logic [IDX_W-1:0] r_b_base;
   logic [IDX_W-1:0] r_out_base;
   logic [2:0]       r_rows;
   logic [2:0]       r_cols;
   logic [DIM_W-1:0] r_klen;
   logic             r_busy;
   logic             r_done;
   logic [4:0]       r_cnt;

   logic             w_go;
   logic             w_zero;
   logic [DIM_W-1:0] w_mt;
   logic [DIM_W-1:0] w_nt;
   logic             w_cwrap;
   logic             w_last;
   logic [DIM_W-1:0] w_nrow;
   logic [DIM_W-1:0] w_ncol;
   logic [DIM_W-1:0] w_fm;
   logic [DIM_W-1:0] w_fk;
   logic [DIM_W-1:0] w_fn;
   logic [DIM_W-1:0] w_frow;
   logic [DIM_W-1:0] w_fcol;
   logic [DIM_W-1:0] w_fnt;
   logic [IDX_W-1:0] w_a;
   logic [IDX_W-1:0] w_b;
   logic [IDX_W-1:0] w_o;
   logic [2:0]       w_rows;
   logic [2:0]       w_cols;

   // A new job is only accepted when no job is in flight.
   assign w_go   = bus.start &&
                   (r_state == S_IDLE || r_state == S_DONE);
   assign w_zero = (bus.m == '0) || (bus.k == '0) ||
                   (bus.n == '0);

   assign w_mt    = f_cnt(r_m);
   assign w_nt    = f_cnt(r_n);
   assign w_cwrap = (r_col == w_nt - L_ONE);
   assign w_last  = w_cwrap && (r_row == w_mt - L_ONE);
   assign w_nrow  = w_cwrap ? r_row + L_ONE : r_row;
   assign w_ncol  = w_cwrap ? '0 : r_col + L_ONE;

   // Fields for the next ISSUE: from the inputs on a fresh job,
   // otherwise from the latched dims and the advanced tile position.
   assign w_fm   = w_go ? bus.m : r_m;
   assign w_fk   = w_go ? bus.k : r_k;
   assign w_fn   = w_go ? bus.n : r_n;
   assign w_frow = w_go ? '0 : w_nrow;
   assign w_fcol = w_go ? '0 : w_ncol;
   assign w_fnt  = f_cnt(w_fn);

   assign w_a    = f_wide(w_frow) * f_wide(w_fk);
   assign w_b    = f_wide(w_fcol) * f_wide(w_fk);
   assign w_o    = (f_wide(w_frow) * f_wide(w_fnt) +
                    f_wide(w_fcol)) * L_DIM;
   assign w_rows = f_ext(w_fm, w_frow);
   assign w_cols = f_ext(w_fn, w_fcol);

   // Job sequencer; every output is a register of this FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_m        <= '0;
         r_k        <= '0;
         r_n        <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_valid    <= 1'b0;
         r_a_base   <= '0;
         r_b_base   <= '0;
         r_out_base <= '0;
         r_rows     <= '0;
         r_cols     <= '0;
         r_klen     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_m   <= bus.m;
                  r_k   <= bus.k;
                  r_n   <= bus.n;
                  r_row <= '0;
                  r_col <= '0;
                  r_cnt <= '0;
                  if (w_zero) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_done     <= 1'b0;
                     r_busy     <= 1'b1;
                     r_valid    <= 1'b1;
                     r_a_base   <= w_a;
                     r_b_base   <= w_b;
                     r_out_base <= w_o;
                     r_rows     <= w_rows;
                     r_cols     <= w_cols;
                     r_klen     <= w_fk;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.tile_ready) begin
                  r_state <= S_WAIT;
                  r_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.tile_done) begin
                  r_cnt <= r_cnt + 5'd1;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_row      <= w_nrow;
                     r_col      <= w_ncol;
                     r_valid    <= 1'b1;
                     r_a_base   <= w_a;
                     r_b_base   <= w_b;
                     r_out_base <= w_o;
                     r_rows     <= w_rows;
                     r_cols     <= w_cols;
                     r_klen     <= w_fk;
                  end
               end
            end
         endcase
      end
   end

   assign bus.tile_valid = r_valid;
   assign bus.a_base     = r_a_base;
   assign bus.b_base     = r_b_base;
   assign bus.out_base   = r_out_base;
   assign bus.tile_rows  = r_rows;
   assign bus.tile_cols  = r_cols;
   assign bus.k_len      = r_klen;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.tile_cnt   = r_cnt;
endmodule
